// File: rtl/seg_disp_drv_if.sv
// Producer-to-display value handshake: din is transferred when din_valid & din_ready.
interface seg_disp_drv_if;
   logic [15:0] din;
   logic        din_valid;
   logic        din_ready;

   modport master (output din, output din_valid, input  din_ready);
   modport slave  (input  din, input  din_valid, output din_ready);
endinterface

// File: rtl/seg_disp_drv.sv
// Segment-side driver for a 4-digit seven-segment display.
// Values are double-buffered through a one-entry shadow slot and committed only
// on a scan-frame boundary, so a frame never shows a torn value. Adds
// leading-zero blanking, per-digit decimal point and per-digit blink.
module seg_disp_drv #(
   parameter int BLINK_W = 25
) (
   input  logic          mclk,
   input  logic          btn3,
   input  logic [3:0]    an,
   seg_disp_drv_if.slave bus,
   input  logic [3:0]    dp_mask,
   input  logic          blank_lz,
   input  logic [3:0]    blink_en,
   output logic [6:0]    seg,
   output logic          dp,
   output logic [3:0]    an_out,
   output logic          frame_done
);

   logic [3:0]         r_an_q;
   logic               r_pending;
   logic [15:0]        r_shadow;
   logic [15:0]        r_disp;
   logic [BLINK_W-1:0] r_cnt;
   logic [6:0]         r_seg;
   logic               r_dp;
   logic [3:0]         r_an_out;
   logic               r_frame_done;

   logic        w_boundary;
   logic        w_accept;
   logic        w_commit;
   logic [15:0] w_disp_nxt;
   logic        w_an_valid;
   logic [1:0]  w_idx;
   logic [3:0]  w_nib;
   logic [6:0]  w_hex;
   logic        w_lz_blank;
   logic        w_blink;
   logic [6:0]  w_seg;
   logic        w_dp;

   // A frame starts when the scan lands on digit 0 coming from anything else.
   assign w_boundary = (an == 4'b1110) && (r_an_q != 4'b1110);
   assign w_accept   = bus.din_valid && !r_pending;
   assign w_commit   = w_boundary && r_pending;
   // The digit shown in the boundary cycle already uses the value being
   // committed, so frame_done lines up with the first digit of the new value.
   assign w_disp_nxt = w_commit ? r_shadow : r_disp;
   assign bus.din_ready = !r_pending;

   // Decode the one-hot-low scan into a digit index; anything else is invalid.
   always_comb begin
      w_an_valid = 1'b1;
      w_idx      = 2'd0;
      case (an)
         4'b1110: w_idx = 2'd0;
         4'b1101: w_idx = 2'd1;
         4'b1011: w_idx = 2'd2;
         4'b0111: w_idx = 2'd3;
         default: w_an_valid = 1'b0;
      endcase
   end

   assign w_nib = w_disp_nxt[{w_idx, 2'b00} +: 4];

   // Active-low hex font, segment order {g,f,e,d,c,b,a}.
   always_comb begin
      w_hex = 7'h7F;
      case (w_nib)
         4'h0: w_hex = 7'h40;
         4'h1: w_hex = 7'h79;
         4'h2: w_hex = 7'h24;
         4'h3: w_hex = 7'h30;
         4'h4: w_hex = 7'h19;
         4'h5: w_hex = 7'h12;
         4'h6: w_hex = 7'h02;
         4'h7: w_hex = 7'h78;
         4'h8: w_hex = 7'h00;
         4'h9: w_hex = 7'h10;
         4'hA: w_hex = 7'h08;
         4'hB: w_hex = 7'h03;
         4'hC: w_hex = 7'h46;
         4'hD: w_hex = 7'h21;
         4'hE: w_hex = 7'h06;
         4'hF: w_hex = 7'h0E;
         default: w_hex = 7'h7F;
      endcase
   end

   // A digit is a leading zero when it and every more-significant digit are zero;
   // digit 0 always shows so a zero value still reads "0".
   always_comb begin
      w_lz_blank = 1'b0;
      case (w_idx)
         2'd3: w_lz_blank = (w_disp_nxt[15:12] == 4'h0);
         2'd2: w_lz_blank = (w_disp_nxt[15:8]  == 8'h00);
         2'd1: w_lz_blank = (w_disp_nxt[15:4]  == 12'h000);
         default: w_lz_blank = 1'b0;
      endcase
      w_lz_blank = w_lz_blank && blank_lz;
   end

   assign w_blink = blink_en[w_idx] && r_cnt[BLINK_W-1];

   // Blink blanks the whole digit including dp; leading-zero blank keeps dp.
   always_comb begin
      w_seg = 7'h7F;
      w_dp  = 1'b1;
      if (w_an_valid) begin
         if (!w_blink) begin
            w_seg = w_lz_blank ? 7'h7F : w_hex;
            w_dp  = ~dp_mask[w_idx];
         end
      end
   end

   // Shadow slot, committed display value, scan history and blink counter.
   always_ff @(posedge mclk) begin
      if (btn3) begin
         r_an_q    <= 4'hF;
         r_pending <= 1'b0;
         r_shadow  <= 16'h0000;
         r_disp    <= 16'h0000;
         r_cnt     <= '0;
      end else begin
         r_an_q <= an;
         r_cnt  <= r_cnt + 1'b1;
         r_disp <= w_disp_nxt;
         if (w_commit) begin
            r_pending <= 1'b0;
         end else if (w_accept) begin
            r_shadow  <= bus.din;
            r_pending <= 1'b1;
         end
      end
   end

   // Register the display outputs so seg/dp stay aligned with the delayed anode bus.
   always_ff @(posedge mclk) begin
      if (btn3) begin
         r_seg        <= 7'h7F;
         r_dp         <= 1'b1;
         r_an_out     <= 4'hF;
         r_frame_done <= 1'b0;
      end else begin
         r_seg        <= w_seg;
         r_dp         <= w_dp;
         r_an_out     <= an;
         r_frame_done <= w_boundary;
      end
   end

   assign seg        = r_seg;
   assign dp         = r_dp;
   assign an_out     = r_an_out;
   assign frame_done = r_frame_done;

endmodule
